// File: rtl/risc8_pkg.sv
// Shared risc8 definitions: interrupt return-stack entry layout and channel limits.
package risc8_pkg;

  localparam int INTR_NCH_MAX = 8;
  localparam int INTR_PCW_MAX = 16;
  localparam int INTR_IDW_MAX = 3;

  // One saved context: where to resume and which channel was being serviced
  typedef struct packed {
    logic [INTR_PCW_MAX-1:0] pc;
    logic [INTR_IDW_MAX-1:0] id;
  } intr_stack_entry_t;

endpackage

// File: rtl/risc_intr_ctrl_prio_enc.sv
// Fixed-priority encoder: lowest set index wins.
module prio_enc #(
  parameter int NCH = 4,
  localparam int IDW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic [NCH-1:0] req,
  output logic [IDW-1:0] idx,
  output logic           valid
);

  // Scan downward so the lowest set bit is the last one written
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = IDW'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/risc_intr_ctrl.sv
// Edge-triggered interrupt controller with vector table and return stack.
// Define RISC_INTR_NEST_EN for nested service up to DEPTH levels; otherwise one level, no preemption.
module risc_intr_ctrl
  import risc8_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int PCW   = 16,
  parameter int DEPTH = 4,
  localparam int IDW  = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int DW   = $clog2(DEPTH + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] irq,
  input  logic           en_we,
  input  logic [NCH-1:0] en_wdata,
  input  logic           vec_we,
  input  logic [IDW-1:0] vec_idx,
  input  logic [PCW-1:0] vec_wdata,
  input  logic [PCW-1:0] pc_in,
  input  logic           take,
  input  logic           reti,
  output logic           intr_req,
  output logic [PCW-1:0] intr_vec,
  output logic [IDW-1:0] intr_id,
  output logic [PCW-1:0] ret_pc,
  output logic [NCH-1:0] pending,
  output logic [DW-1:0]  depth,
  output logic           err
);

`ifdef RISC_INTR_NEST_EN
  localparam int EFF_DEPTH = DEPTH;
`else
  localparam int EFF_DEPTH = 1;
`endif
  localparam logic [DW-1:0] DEPTH_MAX = DW'(EFF_DEPTH);

  logic [NCH-1:0]    irq_q;
  logic [NCH-1:0]    enable;
  logic [NCH-1:0]    pending_q;
  logic [PCW-1:0]    vec [NCH];
  logic [DW-1:0]     depth_q;
  logic              err_q;
  logic [NCH-1:0]    cand_src;
  logic [IDW-1:0]    cand_id;
  logic              cand_valid;
  logic              take_ok;
  logic              reti_ok;
  logic [NCH-1:0]    set_mask;
  logic [NCH-1:0]    clr_mask;
  intr_stack_entry_t top_entry;
  intr_stack_entry_t push_entry;

  assign cand_src = pending_q & enable;

  prio_enc #(.NCH(NCH)) u_prio (
    .req   (cand_src),
    .idx   (cand_id),
    .valid (cand_valid)
  );

  // A request must outrank whatever is currently being serviced
  assign intr_req = cand_valid && (depth_q < DEPTH_MAX) &&
                    ((depth_q == '0) || (INTR_IDW_MAX'(cand_id) < top_entry.id));
  assign intr_id  = cand_id;
  assign intr_vec = vec[cand_id];
  assign ret_pc   = PCW'(top_entry.pc);
  assign pending  = pending_q;
  assign depth    = depth_q;
  assign err      = err_q;

  assign take_ok    = take && intr_req;
  assign reti_ok    = reti && (depth_q != '0);
  assign push_entry = '{pc: INTR_PCW_MAX'(pc_in), id: INTR_IDW_MAX'(cand_id)};
  assign set_mask   = irq & ~irq_q & enable;
  assign clr_mask   = (take_ok ? (NCH'(1) << cand_id) : '0) | (en_we ? ~en_wdata : '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      irq_q     <= '0;
      enable    <= '0;
      pending_q <= '0;
      depth_q   <= '0;
      err_q     <= 1'b0;
      for (int i = 0; i < NCH; i++) vec[i] <= '0;
    end else begin
      irq_q     <= irq;
      pending_q <= (pending_q & ~clr_mask) | set_mask;
      err_q     <= err_q | (take && !intr_req) | (reti && (depth_q == '0));
      if (en_we) enable <= en_wdata;
      if (vec_we && (int'(vec_idx) < NCH)) vec[vec_idx] <= vec_wdata;
      if (take_ok && !reti_ok) depth_q <= depth_q + DW'(1);
      else if (reti_ok && !take_ok) depth_q <= depth_q - DW'(1);
    end
  end

`ifdef RISC_INTR_NEST_EN
  localparam int SW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  intr_stack_entry_t stack [DEPTH];
  logic [SW-1:0]     top_idx;

  assign top_idx   = SW'(depth_q - DW'(1));
  assign top_entry = (depth_q != '0) ? stack[top_idx] : '0;

  // Take alongside reti overwrites the popped slot, so depth stays put
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stack[i] <= '0;
    end else if (take_ok) begin
      stack[reti_ok ? top_idx : SW'(depth_q)] <= push_entry;
    end
  end
`else
  intr_stack_entry_t slot;

  assign top_entry = (depth_q != '0) ? slot : '0;

  always_ff @(posedge clk) begin
    if (rst) slot <= '0;
    else if (take_ok) slot <= push_entry;
  end
`endif

endmodule

// File: tb/tb_risc_intr_ctrl.sv
// Scoreboard bench for risc_intr_ctrl: directed scenarios then randomized traffic against a queue-based model.
module tb_risc_intr_ctrl;

  localparam int NCH = 4;
  localparam int PCW = 16;
  localparam int DEPTH = 4;
`ifdef RISC_INTR_NEST_EN
  localparam int MAXD = DEPTH;
`else
  localparam int MAXD = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] irq = '0;
  logic en_we = 1'b0;
  logic [3:0] en_wdata = '0;
  logic vec_we = 1'b0;
  logic [1:0] vec_idx = '0;
  logic [15:0] vec_wdata = '0;
  logic [15:0] pc_in = '0;
  logic take = 1'b0;
  logic reti = 1'b0;
  logic intr_req;
  logic [15:0] intr_vec;
  logic [1:0] intr_id;
  logic [15:0] ret_pc;
  logic [3:0] pending;
  logic [2:0] depth;
  logic err;

  risc_intr_ctrl #(.NCH(NCH), .PCW(PCW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .irq(irq), .en_we(en_we), .en_wdata(en_wdata),
    .vec_we(vec_we), .vec_idx(vec_idx), .vec_wdata(vec_wdata), .pc_in(pc_in),
    .take(take), .reti(reti), .intr_req(intr_req), .intr_vec(intr_vec),
    .intr_id(intr_id), .ret_pc(ret_pc), .pending(pending), .depth(depth), .err(err)
  );

  always #5 clk = ~clk;

  // Staged stimulus, copied onto the DUT inputs at the next falling edge
  logic s_rst = 1'b0, s_en_we = 1'b0, s_vec_we = 1'b0, s_take = 1'b0, s_reti = 1'b0;
  logic [3:0] s_irq = '0, s_en_wdata = '0;
  logic [1:0] s_vec_idx = '0;
  logic [15:0] s_vec_wdata = '0, s_pc = '0;

  typedef struct { logic [15:0] pc; int id; } ent_t;
  typedef struct {
    logic req; logic [1:0] id; logic [15:0] vec; logic [15:0] ret_pc;
    logic [3:0] pending; logic [2:0] depth; logic err; int cyc;
  } exp_t;

  logic [3:0] m_pending, m_enable, m_irq_prev;
  logic [15:0] m_vec [4];
  logic m_err;
  ent_t m_stack[$];
  bit model_valid = 0;
  exp_t exp_q[$];
  int cyc = 0;
  int checks = 0;
  int errors = 0;

  function automatic int m_cand();
    for (int i = 0; i < NCH; i++) if (m_pending[i] && m_enable[i]) return i;
    return -1;
  endfunction

  function automatic bit m_req();
    int c = m_cand();
    if (c < 0 || m_stack.size() >= MAXD) return 0;
    if (m_stack.size() == 0) return 1;
    return c < m_stack[$].id;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv, input int at);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s cycle %0d: got %0h, expected %0h", name, at, act, expv);
    end
  endtask

  task automatic applyStimulus();
    exp_t e;
    int c;
    bit rq, take_ok, reti_ok;
    logic [3:0] clr, edges;
    @(negedge clk);
    rst = s_rst; irq = s_irq; en_we = s_en_we; en_wdata = s_en_wdata;
    vec_we = s_vec_we; vec_idx = s_vec_idx; vec_wdata = s_vec_wdata;
    pc_in = s_pc; take = s_take; reti = s_reti;
    c = m_cand();
    rq = m_req();
    if (model_valid) begin
      e.req = rq;
      e.id = (c >= 0) ? 2'(c) : 2'd0;
      e.vec = (c >= 0) ? m_vec[c] : 16'h0;
      e.ret_pc = (m_stack.size() > 0) ? m_stack[$].pc : 16'h0;
      e.pending = m_pending;
      e.depth = 3'(m_stack.size());
      e.err = m_err;
      e.cyc = cyc;
      exp_q.push_back(e);
    end
    if (s_rst) begin
      m_pending = '0; m_enable = '0; m_irq_prev = '0; m_err = 0;
      for (int i = 0; i < 4; i++) m_vec[i] = '0;
      m_stack.delete();
    end else begin
      take_ok = s_take && rq;
      reti_ok = s_reti && (m_stack.size() > 0);
      if (s_take && !rq) m_err = 1;
      if (s_reti && m_stack.size() == 0) m_err = 1;
      edges = s_irq & ~m_irq_prev & m_enable;
      clr = '0;
      if (take_ok) clr[c] = 1'b1;
      if (s_en_we) clr = clr | ~s_en_wdata;
      m_pending = (m_pending & ~clr) | edges;
      if (reti_ok) void'(m_stack.pop_back());
      if (take_ok) m_stack.push_back('{pc: s_pc, id: c});
      if (s_en_we) m_enable = s_en_wdata;
      if (s_vec_we && int'(s_vec_idx) < NCH) m_vec[s_vec_idx] = s_vec_wdata;
      m_irq_prev = s_irq;
    end
    model_valid = 1;
    cyc++;
    s_rst = 0; s_en_we = 0; s_vec_we = 0; s_take = 0; s_reti = 0;
  endtask

  task automatic sample();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    s_rst = 1; applyStimulus();
  endtask

  task automatic writeVec(input logic [1:0] idx, input logic [15:0] v);
    s_vec_we = 1; s_vec_idx = idx; s_vec_wdata = v; applyStimulus();
  endtask

  task automatic writeEn(input logic [3:0] m);
    s_en_we = 1; s_en_wdata = m; applyStimulus();
  endtask

  task automatic setIrq(input logic [3:0] m);
    s_irq = m; applyStimulus();
  endtask

  task automatic doTake(input logic [15:0] pc);
    s_take = 1; s_pc = pc; applyStimulus();
  endtask

  task automatic doReti();
    s_reti = 1; applyStimulus();
  endtask

  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      if (m_req()) doTake(16'h0300 + 16'(i));
      else if (m_stack.size() > 0) doReti();
      else break;
    end
  endtask

  task automatic loadVectors();
    writeVec(2'd0, 16'h0100);
    writeVec(2'd1, 16'h0110);
    writeVec(2'd2, 16'h0120);
    writeVec(2'd3, 16'h0130);
  endtask

  // Monitor: every cycle the DUT presents its registered outputs, compare against the oldest prediction
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("intr_req", 32'(intr_req), 32'(e.req), e.cyc);
        checkOutput("ret_pc", 32'(ret_pc), 32'(e.ret_pc), e.cyc);
        checkOutput("pending", 32'(pending), 32'(e.pending), e.cyc);
        checkOutput("depth", 32'(depth), 32'(e.depth), e.cyc);
        checkOutput("err", 32'(err), 32'(e.err), e.cyc);
        if (e.req) begin
          checkOutput("intr_id", 32'(intr_id), 32'(e.id), e.cyc);
          checkOutput("intr_vec", 32'(intr_vec), 32'(e.vec), e.cyc);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset and basic single-channel service
    doReset();
    doReset(); sample();
    checkOutput("rst_req", 32'(intr_req), 32'h0, cyc);
    checkOutput("rst_vec", 32'(intr_vec), 32'h0, cyc);
    checkOutput("rst_id", 32'(intr_id), 32'h0, cyc);
    checkOutput("rst_ret_pc", 32'(ret_pc), 32'h0, cyc);
    checkOutput("rst_depth", 32'(depth), 32'h0, cyc);
    checkOutput("rst_err", 32'(err), 32'h0, cyc);
    loadVectors();
    writeEn(4'b0100);
    setIrq(4'b0100); sample();
    checkOutput("a_req", 32'(intr_req), 32'h1, cyc);
    checkOutput("a_vec", 32'(intr_vec), 32'h0120, cyc);
    checkOutput("a_id", 32'(intr_id), 32'h2, cyc);
    doTake(16'h0042); sample();
    checkOutput("a_take_depth", 32'(depth), 32'h1, cyc);
    checkOutput("a_take_ret_pc", 32'(ret_pc), 32'h0042, cyc);
    checkOutput("a_take_pending", 32'(pending), 32'h0, cyc);
    doReti(); sample();
    checkOutput("a_reti_depth", 32'(depth), 32'h0, cyc);
    checkOutput("a_reti_pending", 32'(pending), 32'h0, cyc);

    // Preemption by a higher-priority channel, none by a lower one
    setIrq(4'b0000);
    writeEn(4'b1111);
    setIrq(4'b0100);
    doTake(16'h0200);
    setIrq(4'b1100); sample();
    checkOutput("b_low_req", 32'(intr_req), 32'h0, cyc);
    checkOutput("b_low_pending", 32'(pending), 32'h8, cyc);
    setIrq(4'b1101); sample();
`ifdef RISC_INTR_NEST_EN
    checkOutput("b_nest_req", 32'(intr_req), 32'h1, cyc);
    checkOutput("b_nest_vec", 32'(intr_vec), 32'h0100, cyc);
    doTake(16'h0210); sample();
    checkOutput("b_nest_depth", 32'(depth), 32'h2, cyc);
    doReti(); sample();
    checkOutput("b_reti1_req", 32'(intr_req), 32'h0, cyc);
    checkOutput("b_reti1_ret_pc", 32'(ret_pc), 32'h0200, cyc);
    doReti(); sample();
    checkOutput("b_reti2_vec", 32'(intr_vec), 32'h0130, cyc);
`else
    checkOutput("b_nonest_req", 32'(intr_req), 32'h0, cyc);
    doReti(); sample();
    checkOutput("b_reti_req", 32'(intr_req), 32'h1, cyc);
    checkOutput("b_reti_vec", 32'(intr_vec), 32'h0100, cyc);
`endif
    drain();
    setIrq(4'b0000);

`ifdef RISC_INTR_NEST_EN
    // Fill the stack, then show a held request is serviced after one return
    for (int b = 3; b >= 0; b--) begin
      s_irq[b] = 1'b1;
      applyStimulus();
      doTake(16'h0400 + 16'(b));
    end
    sample();
    checkOutput("c_full_depth", 32'(depth), 32'h4, cyc);
    setIrq(4'b0000);
    setIrq(4'b0001); sample();
    checkOutput("c_full_req", 32'(intr_req), 32'h0, cyc);
    checkOutput("c_full_pending", 32'(pending), 32'h1, cyc);
    doReti(); sample();
    checkOutput("c_after_reti_req", 32'(intr_req), 32'h1, cyc);
    drain();
    setIrq(4'b0000);
`endif

    // Illegal events set the sticky error flag
    doReset();
    doReti(); sample();
    checkOutput("d_reti_err", 32'(err), 32'h1, cyc);
    checkOutput("d_reti_depth", 32'(depth), 32'h0, cyc);
    doReset();
    doTake(16'h0500); sample();
    checkOutput("d_take_err", 32'(err), 32'h1, cyc);

    // Reset in the middle of service overrides simultaneous take/reti/writes
    doReset();
    loadVectors();
    writeEn(4'b1111);
    setIrq(4'b0100);
    doTake(16'h0600);
`ifdef RISC_INTR_NEST_EN
    setIrq(4'b0101);
    doTake(16'h0610);
    setIrq(4'b1111); sample();
    checkOutput("e_depth", 32'(depth), 32'h2, cyc);
`else
    setIrq(4'b1110); sample();
    checkOutput("e_depth", 32'(depth), 32'h1, cyc);
`endif
    checkOutput("e_pending", 32'(pending), 32'ha, cyc);
    s_rst = 1; s_take = 1; s_reti = 1; s_en_we = 1; s_en_wdata = 4'b1111;
    s_vec_we = 1; s_vec_idx = 2'd0; s_vec_wdata = 16'hbeef;
    applyStimulus(); sample();
    checkOutput("e_rst_pending", 32'(pending), 32'h0, cyc);
    checkOutput("e_rst_depth", 32'(depth), 32'h0, cyc);
    checkOutput("e_rst_req", 32'(intr_req), 32'h0, cyc);
    checkOutput("e_rst_err", 32'(err), 32'h0, cyc);
    checkOutput("e_rst_vec", 32'(intr_vec), 32'h0, cyc);
    writeEn(4'b1111);
    applyStimulus(); sample();
    checkOutput("e_no_latch", 32'(pending), 32'h0, cyc);

    // Randomized traffic checked by the scoreboard
    doReset();
    loadVectors();
    for (int k = 0; k < 500; k++) begin
      if ($urandom_range(0, 3) == 0) s_irq = 4'($urandom);
      if ($urandom_range(0, 9) == 0) begin
        s_en_we = 1; s_en_wdata = ($urandom_range(0, 2) == 0) ? 4'b1111 : 4'($urandom);
      end
      if ($urandom_range(0, 9) == 0) begin
        s_vec_we = 1; s_vec_idx = 2'($urandom); s_vec_wdata = 16'($urandom);
      end
      s_take = m_req() ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 39) == 0);
      s_pc = 16'($urandom);
      s_reti = ($urandom_range(0, 5) == 0);
      s_rst = ($urandom_range(0, 149) == 0);
      applyStimulus();
    end
    applyStimulus();

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d entries left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
